// File: rtl/handle_factory.sv
// Handle factory: shared pool of resource handles for several
// client families, with per-family quotas and double-free checks.
module handle_factory #(
  parameter int NUM_FAMILIES = 4,
  parameter int DEPTH = 16,
  parameter int QUOTA = 8,
  localparam int FW = (NUM_FAMILIES > 1) ? $clog2(NUM_FAMILIES) : 1,
  localparam int HW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_valid,
  input  logic [FW-1:0] alloc_family,
  output logic          alloc_ready,
  output logic [HW-1:0] alloc_handle,
  input  logic          free_valid,
  input  logic [HW-1:0] free_handle,
  output logic          free_err,
  output logic [HW:0]   free_count,
  output logic          init_done
);

  localparam int QW = $clog2(QUOTA + 1);
  localparam logic [QW-1:0] QUOTA_V = QW'(QUOTA);
  localparam logic [HW-1:0] LAST = HW'(DEPTH - 1);
  localparam logic [HW:0] ONE_C = (HW+1)'(1);
  localparam logic [QW-1:0] ONE_Q = QW'(1);

  typedef enum logic {
    S_INIT,
    S_READY
  } state_t;

  state_t        state;
  logic [HW-1:0] fifo [DEPTH];
  logic [FW-1:0] owner [DEPTH];
  logic [QW-1:0] outst [NUM_FAMILIES];
  logic [DEPTH-1:0] used;
  logic [HW-1:0] head;
  logic [HW-1:0] tail;
  logic [HW:0]   count;

  logic          fam_ok;
  logic [QW-1:0] fam_cnt;
  logic          fire;
  logic          free_ok;
  logic          free_fire;
  logic [FW-1:0] free_owner;
  logic [NUM_FAMILIES-1:0] fam_inc;
  logic [NUM_FAMILIES-1:0] fam_dec;

  function automatic logic [HW-1:0] nxt(
    input logic [HW-1:0] p
  );
    return (p == LAST) ? '0 : p + HW'(1);
  endfunction

  always_comb begin
    fam_ok = int'(alloc_family) < NUM_FAMILIES;
    fam_cnt = '0;
    if (fam_ok) fam_cnt = outst[alloc_family];
    alloc_ready = (state == S_READY)
      && (count != '0)
      && fam_ok
      && (fam_cnt < QUOTA_V);
    fire = alloc_valid && alloc_ready;
    alloc_handle = fifo[head];
    free_ok = 1'b0;
    free_owner = '0;
    if (state == S_READY && int'(free_handle) < DEPTH) begin
      free_ok = used[free_handle];
      free_owner = owner[free_handle];
    end
    free_fire = free_valid && free_ok;
    for (int f = 0; f < NUM_FAMILIES; f++) begin
      fam_inc[f] = fire && (alloc_family == FW'(f));
      fam_dec[f] = free_fire && (free_owner == FW'(f));
    end
  end

  assign free_count = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_INIT;
      head <= '0;
      tail <= '0;
      count <= '0;
      used <= '0;
      free_err <= 1'b0;
      init_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo[i] <= '0;
        owner[i] <= '0;
      end
      for (int f = 0; f < NUM_FAMILIES; f++) begin
        outst[f] <= '0;
      end
    end else begin
      free_err <= free_valid && !free_ok;
      unique case (state)
        S_INIT: begin
          // tail doubles as the init write index
          fifo[tail] <= tail;
          tail <= nxt(tail);
          count <= count + ONE_C;
          if (tail == LAST) begin
            state <= S_READY;
            init_done <= 1'b1;
          end
        end
        S_READY: begin
          if (fire) begin
            head <= nxt(head);
            used[alloc_handle] <= 1'b1;
            owner[alloc_handle] <= alloc_family;
          end
          if (free_fire) begin
            fifo[tail] <= free_handle;
            tail <= nxt(tail);
            used[free_handle] <= 1'b0;
          end
          if (fire && !free_fire) begin
            count <= count - ONE_C;
          end else if (free_fire && !fire) begin
            count <= count + ONE_C;
          end
          for (int f = 0; f < NUM_FAMILIES; f++) begin
            if (fam_inc[f] && !fam_dec[f]) begin
              outst[f] <= outst[f] + ONE_Q;
            end else if (fam_dec[f] && !fam_inc[f]) begin
              outst[f] <= outst[f] - ONE_Q;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handle_factory.sv
// Directed bench for handle_factory: vector table plus
// hand-written init, wrap, reset and quota sequences.
module tb_handle_factory;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid;
  logic [1:0] alloc_family;
  logic       alloc_ready;
  logic [3:0] alloc_handle;
  logic       free_valid;
  logic [3:0] free_handle;
  logic       free_err;
  logic [4:0] free_count;
  logic       init_done;

  int pass_cnt = 0;
  int total_cnt = 0;

  handle_factory dut (
    .clk(clk),
    .rst(rst),
    .alloc_valid(alloc_valid),
    .alloc_family(alloc_family),
    .alloc_ready(alloc_ready),
    .alloc_handle(alloc_handle),
    .free_valid(free_valid),
    .free_handle(free_handle),
    .free_err(free_err),
    .free_count(free_count),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       av;
    logic [1:0] fam;
    logic       fv;
    logic [3:0] fh;
    logic       rdy;
    logic       chk_h;
    logic [3:0] h;
    logic       err;
    logic [4:0] cnt;
  } vec_t;

  vec_t tbl [30];

  function automatic vec_t mk(
    input logic av, input int fam,
    input logic fv, input int fh,
    input logic rdy, input logic chk_h,
    input int h, input logic err, input int cnt
  );
    vec_t v;
    v.av = av;
    v.fam = 2'(fam);
    v.fv = fv;
    v.fh = 4'(fh);
    v.rdy = rdy;
    v.chk_h = chk_h;
    v.h = 4'(h);
    v.err = err;
    v.cnt = 5'(cnt);
    return v;
  endfunction

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int perm(input int c, input int k);
    return (k * 5 + c * 3) % 16;
  endfunction

  initial begin
    // 16 allocs rotating families, then exhaustion
    for (int i = 0; i < 16; i++)
      tbl[i] = mk(1, i % 4, 0, 0, 1, 1, i, 0, 16 - i);
    tbl[16] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // empty pool: alloc + free 5 same cycle
    tbl[17] = mk(1, 1, 1, 5, 0, 0, 0, 0, 0);
    tbl[18] = mk(1, 1, 0, 0, 1, 1, 5, 0, 1);
    // double free of 3
    tbl[19] = mk(0, 0, 1, 3, 0, 0, 0, 0, 0);
    tbl[20] = mk(0, 0, 1, 3, 1, 1, 3, 0, 1);
    tbl[21] = mk(0, 0, 0, 0, 1, 1, 3, 1, 1);
    // FIFO order of return: 3,7,2,9
    tbl[22] = mk(0, 0, 1, 7, 1, 1, 3, 0, 1);
    tbl[23] = mk(0, 0, 1, 2, 1, 1, 3, 0, 2);
    tbl[24] = mk(0, 0, 1, 9, 1, 1, 3, 0, 3);
    tbl[25] = mk(1, 0, 0, 0, 1, 1, 3, 0, 4);
    tbl[26] = mk(1, 1, 0, 0, 1, 1, 7, 0, 3);
    tbl[27] = mk(1, 2, 0, 0, 1, 1, 2, 0, 2);
    tbl[28] = mk(1, 3, 0, 0, 1, 1, 9, 0, 1);
    tbl[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    rst = 1'b1;
    alloc_valid = 1'b0;
    alloc_family = 2'd0;
    free_valid = 1'b0;
    free_handle = 4'd0;
    cyc();
    chk("rst_ready", 32'(alloc_ready), 0);
    chk("rst_handle", 32'(alloc_handle), 0);
    chk("rst_err", 32'(free_err), 0);
    chk("rst_count", 32'(free_count), 0);
    chk("rst_init", 32'(init_done), 0);

    // free during INIT is flagged and ignored
    rst = 1'b0;
    free_valid = 1'b1;
    free_handle = 4'd3;
    cyc();
    chk("init_free_err", 32'(free_err), 1);
    free_valid = 1'b0;
    repeat (14) cyc();
    chk("init_not_done", 32'(init_done), 0);
    cyc();
    chk("init_done", 32'(init_done), 1);
    chk("init_count", 32'(free_count), 16);
    chk("init_err_clr", 32'(free_err), 0);

    for (int i = 0; i < 30; i++) begin
      alloc_valid = tbl[i].av;
      alloc_family = tbl[i].fam;
      free_valid = tbl[i].fv;
      free_handle = tbl[i].fh;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(alloc_ready), 32'(tbl[i].rdy));
      if (tbl[i].chk_h)
        chk($sformatf("v%0d_handle", i), 32'(alloc_handle), 32'(tbl[i].h));
      chk($sformatf("v%0d_err", i), 32'(free_err), 32'(tbl[i].err));
      chk($sformatf("v%0d_count", i), 32'(free_count), 32'(tbl[i].cnt));
      cyc();
    end
    alloc_valid = 1'b0;
    free_valid = 1'b0;

    // three full free/alloc rounds across pointer wrap
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 16; k++) begin
        free_valid = 1'b1;
        free_handle = 4'(perm(c, k));
        cyc();
      end
      free_valid = 1'b0;
      chk($sformatf("wrap%0d_count_full", c), 32'(free_count), 16);
      chk($sformatf("wrap%0d_err", c), 32'(free_err), 0);
      for (int k = 0; k < 16; k++) begin
        alloc_valid = 1'b1;
        alloc_family = 2'(k % 4);
        #1;
        chk($sformatf("wrap%0d_rdy%0d", c, k), 32'(alloc_ready), 1);
        chk($sformatf("wrap%0d_h%0d", c, k), 32'(alloc_handle),
            32'(perm(c, k)));
        cyc();
      end
      alloc_valid = 1'b0;
      chk($sformatf("wrap%0d_count_empty", c), 32'(free_count), 0);
    end

    // reset with 10 handles outstanding
    for (int k = 0; k < 6; k++) begin
      free_valid = 1'b1;
      free_handle = 4'(perm(2, k));
      cyc();
    end
    free_valid = 1'b0;
    chk("pre_rst_count", 32'(free_count), 6);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(alloc_ready), 0);
    chk("mid_rst_handle", 32'(alloc_handle), 0);
    chk("mid_rst_count", 32'(free_count), 0);
    chk("mid_rst_init", 32'(init_done), 0);
    cyc();
    cyc();
    rst = 1'b0;
    repeat (16) cyc();
    chk("reinit_done", 32'(init_done), 1);
    chk("reinit_count", 32'(free_count), 16);
    alloc_family = 2'd0;
    #1;
    chk("reinit_ready", 32'(alloc_ready), 1);
    chk("reinit_handle", 32'(alloc_handle), 0);

    // quota: family 2 takes 8 handles
    for (int k = 0; k < 8; k++) begin
      alloc_valid = 1'b1;
      alloc_family = 2'd2;
      #1;
      chk($sformatf("q_rdy%0d", k), 32'(alloc_ready), 1);
      chk($sformatf("q_h%0d", k), 32'(alloc_handle), 32'(k));
      cyc();
    end
    alloc_family = 2'd2;
    #1;
    chk("q_blocked", 32'(alloc_ready), 0);
    alloc_family = 2'd1;
    #1;
    chk("q_other_rdy", 32'(alloc_ready), 1);
    chk("q_other_h", 32'(alloc_handle), 8);
    cyc();
    alloc_valid = 1'b0;
    alloc_family = 2'd2;
    free_valid = 1'b1;
    free_handle = 4'd3;
    #1;
    chk("q_still_blocked", 32'(alloc_ready), 0);
    cyc();
    free_valid = 1'b0;
    alloc_valid = 1'b1;
    #1;
    chk("q_unblocked", 32'(alloc_ready), 1);
    chk("q_unblk_h", 32'(alloc_handle), 9);
    chk("q_count", 32'(free_count), 8);
    cyc();
    alloc_valid = 1'b0;

    // free of a never-allocated handle
    free_valid = 1'b1;
    free_handle = 4'd12;
    cyc();
    free_valid = 1'b0;
    chk("bad_free_err", 32'(free_err), 1);
    chk("bad_free_count", 32'(free_count), 7);
    cyc();
    chk("bad_free_pulse", 32'(free_err), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
